wb_burst_mem_slave: RTL and testbench

Wishbone B3 responder with an internal word-addressed memory. It is the slave-side counterpart to the bus-functional master used in the Wishbone bench. It serves classic single cycles and registered-feedback bursts: constant, incrementing linear, and wrap-4/8/16. Read data is prefetched so a burst completes one beat per clock. Out-of-range accesses are flagged with `wb_err_o`.

---
 rtl/wb_burst_mem_slave.sv | 143 ++++++++++++++
 tb/tb_wb_burst_mem_slave.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_burst_mem_slave.sv
// Wishbone B3 memory responder with registered-feedback burst support.
// Serves classic cycles and constant / linear / wrap-4/8/16 bursts from an
// internal word-addressed memory. Read data for the next beat is prefetched
// so a burst runs at one beat per clock; out-of-range accesses end with err.
module wb_burst_mem_slave #(
  parameter int aw        = 32,
  parameter int dw        = 32,
  parameter int MEM_WORDS = 1024
) (
  input  logic          wb_clk_i,
  input  logic          wb_rst_ni,
  input  logic [aw-1:0] wb_adr_i,
  input  logic [dw-1:0] wb_dat_i,
  input  logic [3:0]    wb_sel_i,
  input  logic          wb_we_i,
  input  logic          wb_cyc_i,
  input  logic          wb_stb_i,
  input  logic [2:0]    wb_cti_i,
  input  logic [1:0]    wb_bte_i,
  output logic [dw-1:0] wb_sdt_o,
  output logic          wb_ack_o,
  output logic          wb_err_o,
  output logic          wb_rty_o
);

  localparam int IW = $clog2(MEM_WORDS);
  localparam logic [aw:0] ADR_LIMIT = (aw+1)'(4 * MEM_WORDS);

  typedef enum logic {IDLE, BURST} state_t;

  state_t          state_q, state_d;
  logic            ack_q, ack_d;
  logic            err_q, err_d;
  logic [aw-1:0]   cur_q, cur_d;
  logic [dw-1:0]   sdt_q;
  logic [dw-1:0]   mem [MEM_WORDS];

  logic            req;
  logic            adr_oor;
  logic            nxt_oor;
  logic [aw-1:0]   nxt_adr;
  logic [IW-1:0]   adr_idx;
  logic [IW-1:0]   rd_idx;
  logic            rd_en;
  logic            mem_we;

  assign req      = wb_cyc_i & wb_stb_i;
  assign adr_idx  = wb_adr_i[2 +: IW];
  assign adr_oor  = {1'b0, wb_adr_i} >= ADR_LIMIT;
  assign nxt_oor  = {1'b0, nxt_adr} >= ADR_LIMIT;

  assign wb_sdt_o = sdt_q;
  assign wb_ack_o = ack_q;
  assign wb_err_o = err_q;
  assign wb_rty_o = 1'b0;

  // Address of the beat following the current one, per cycle/burst type.
  always_comb begin
    nxt_adr = cur_q;
    if (wb_cti_i == 3'b010) begin
      unique case (wb_bte_i)
        2'b00: nxt_adr = cur_q + aw'(4);
        2'b01: nxt_adr = {cur_q[aw-1:4], cur_q[3:2] + 2'd1, cur_q[1:0]};
        2'b10: nxt_adr = {cur_q[aw-1:5], cur_q[4:2] + 3'd1, cur_q[1:0]};
        2'b11: nxt_adr = {cur_q[aw-1:6], cur_q[5:2] + 4'd1, cur_q[1:0]};
      endcase
    end
  end

  // Next-state, termination and prefetch decisions.
  always_comb begin
    state_d = state_q;
    ack_d   = ack_q;
    err_d   = err_q;
    cur_d   = cur_q;
    rd_en   = 1'b0;
    rd_idx  = adr_idx;
    mem_we  = 1'b0;
    if (!req) begin
      ack_d   = 1'b0;
      err_d   = 1'b0;
      state_d = IDLE;
    end else if (err_q) begin
      // error beat is being accepted: one cycle only
      err_d   = 1'b0;
      state_d = IDLE;
    end else if (ack_q) begin
      mem_we = wb_we_i & ~adr_oor;
      if (state_q == BURST && wb_cti_i != 3'b111 && wb_adr_i == cur_q) begin
        if (nxt_oor) begin
          ack_d   = 1'b0;
          err_d   = 1'b1;
          state_d = IDLE;
        end else begin
          cur_d  = nxt_adr;
          rd_en  = 1'b1;
          rd_idx = nxt_adr[2 +: IW];
        end
      end else begin
        // classic beat, end-of-burst, or address break: finish and re-arm
        ack_d   = 1'b0;
        state_d = IDLE;
      end
    end else begin
      state_d = IDLE;
      if (adr_oor) begin
        err_d = 1'b1;
      end else begin
        ack_d = 1'b1;
        rd_en = 1'b1;
        cur_d = wb_adr_i;
        if (wb_cti_i == 3'b001 || wb_cti_i == 3'b010) state_d = BURST;
      end
    end
  end

  // State, handshake and read-data registers.
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      state_q <= IDLE;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      cur_q   <= '0;
      sdt_q   <= '0;
    end else begin
      state_q <= state_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
      cur_q   <= cur_d;
      if (rd_en) sdt_q <= mem[rd_idx];
    end
  end

  // Byte-lane writes on accepted beats; memory contents survive reset.
  always_ff @(posedge wb_clk_i) begin
    if (mem_we) begin
      for (int unsigned b = 0; b < 4; b++) begin
        if (wb_sel_i[b]) mem[adr_idx][8*b +: 8] <= wb_dat_i[8*b +: 8];
      end
    end
  end

endmodule

// File: tb/tb_wb_burst_mem_slave.sv
// Directed bench for wb_burst_mem_slave: a table of classic accesses plus
// hand-written burst, stall, error and reset sequences.
module tb_wb_burst_mem_slave;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] adr = '0;
  logic [31:0] dat = '0;
  logic [3:0]  sel = '0;
  logic        we = 1'b0;
  logic        cyc = 1'b0;
  logic        stb = 1'b0;
  logic [2:0]  cti = '0;
  logic [1:0]  bte = '0;
  logic [31:0] sdt;
  logic        ack;
  logic        err;
  logic        rty;

  int n_pass = 0;
  int n_total = 0;

  logic [31:0] wbuf [16];
  logic [31:0] rbuf [16];

  wb_burst_mem_slave #(.aw(32), .dw(32), .MEM_WORDS(1024)) dut (
    .wb_clk_i (clk),
    .wb_rst_ni(rst_n),
    .wb_adr_i (adr),
    .wb_dat_i (dat),
    .wb_sel_i (sel),
    .wb_we_i  (we),
    .wb_cyc_i (cyc),
    .wb_stb_i (stb),
    .wb_cti_i (cti),
    .wb_bte_i (bte),
    .wb_sdt_o (sdt),
    .wb_ack_o (ack),
    .wb_err_o (err),
    .wb_rty_o (rty)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
    else n_pass++;
  endtask

  function automatic logic [31:0] tb_next(input logic [31:0] a, input logic [2:0] c, input logic [1:0] b);
    logic [31:0] r;
    r = a;
    if (c == 3'b010) begin
      case (b)
        2'b00: r = a + 32'd4;
        2'b01: r[3:2] = a[3:2] + 2'd1;
        2'b10: r[4:2] = a[4:2] + 3'd1;
        default: r[5:2] = a[5:2] + 4'd1;
      endcase
    end
    return r;
  endfunction

  // One classic access; reports latency, termination and whether both
  // handshake outputs are low on the cycle after acceptance.
  task automatic classic(input logic we_v, input logic [31:0] a, input logic [31:0] d,
                         input logic [3:0] s, output logic [31:0] rd, output int lat,
                         output logic got_ack, output logic got_err, output logic tail_ok);
    @(posedge clk); #1;
    adr = a; dat = d; sel = s; we = we_v; cti = 3'b000; bte = 2'b00;
    cyc = 1'b1; stb = 1'b1;
    lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
    end while (!ack && !err && lat < 8);
    got_ack = ack; got_err = err; rd = sdt;
    @(posedge clk); #1;
    tail_ok = !ack && !err;
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
  endtask

  // Registered-feedback burst of n beats; stops early on an error beat.
  task automatic burst(input logic [31:0] start, input logic [2:0] c, input logic [1:0] b,
                       input int n, input logic we_v, output int acks, output int cycles,
                       output logic saw_err);
    int i;
    logic accepted;
    i = 0; acks = 0; cycles = 0; saw_err = 1'b0;
    @(posedge clk); #1;
    adr = start; dat = wbuf[0]; sel = 4'hF; we = we_v; bte = b;
    cti = (n == 1) ? 3'b111 : c;
    cyc = 1'b1; stb = 1'b1;
    while (i < n && cycles < 50 && !saw_err) begin
      @(negedge clk);
      cycles++;
      accepted = ack | err;
      if (ack && i < 16) begin rbuf[i] = sdt; acks++; end
      if (err) saw_err = 1'b1;
      @(posedge clk); #1;
      if (accepted) begin
        i++;
        adr = tb_next(adr, c, b);
        if (i < 16) dat = wbuf[i];
        cti = (i == n - 1) ? 3'b111 : c;
      end
    end
    cyc = 1'b0; stb = 1'b0; we = 1'b0; cti = 3'b000;
  endtask

  typedef struct {
    logic        we;
    logic [31:0] adr;
    logic [31:0] dat;
    logic [3:0]  sel;
    logic        exp_err;
    logic        chk_dat;
    logic [31:0] exp_dat;
  } vec_t;

  vec_t vecs [15];

  initial begin
    logic [31:0] rd;
    int lat, acks, cycles;
    logic ga, ge, tail, serr;

    vecs[0]  = '{1'b1, 32'h0000_0010, 32'hDEADBEEF, 4'hF, 1'b0, 1'b0, 32'h0};
    vecs[1]  = '{1'b0, 32'h0000_0010, 32'h0,        4'hF, 1'b0, 1'b1, 32'hDEADBEEF};
    vecs[2]  = '{1'b1, 32'h0000_0014, 32'hAAAAAAAA, 4'hF, 1'b0, 1'b0, 32'h0};
    vecs[3]  = '{1'b1, 32'h0000_0014, 32'h11223344, 4'h5, 1'b0, 1'b0, 32'h0};
    vecs[4]  = '{1'b0, 32'h0000_0014, 32'h0,        4'hF, 1'b0, 1'b1, 32'hAA22AA44};
    vecs[5]  = '{1'b0, 32'h0000_1000, 32'h0,        4'hF, 1'b1, 1'b0, 32'h0};
    vecs[6]  = '{1'b1, 32'h0000_0FFC, 32'h12345678, 4'hF, 1'b0, 1'b0, 32'h0};
    vecs[7]  = '{1'b1, 32'h0000_0FF8, 32'h87654321, 4'hF, 1'b0, 1'b0, 32'h0};
    vecs[8]  = '{1'b0, 32'h0000_0FFC, 32'h0,        4'hF, 1'b0, 1'b1, 32'h12345678};
    vecs[9]  = '{1'b1, 32'h0000_0000, 32'h55555555, 4'hF, 1'b0, 1'b0, 32'h0};
    vecs[10] = '{1'b1, 32'h0000_1000, 32'hBADBAD00, 4'hF, 1'b1, 1'b0, 32'h0};
    vecs[11] = '{1'b0, 32'h0000_0000, 32'h0,        4'hF, 1'b0, 1'b1, 32'h55555555};
    vecs[12] = '{1'b0, 32'h0000_0013, 32'h0,        4'hF, 1'b0, 1'b1, 32'hDEADBEEF};
    vecs[13] = '{1'b0, 32'h8000_0010, 32'h0,        4'hF, 1'b1, 1'b0, 32'h0};
    vecs[14] = '{1'b1, 32'h0000_0020, 32'hC0FFEE00, 4'hF, 1'b0, 1'b0, 32'h0};
    for (int i = 0; i < 16; i++) begin wbuf[i] = '0; rbuf[i] = '0; end

    // reset state
    repeat (3) @(posedge clk);
    #1;
    check("reset_ack", {31'b0, ack}, 32'h0);
    check("reset_err", {31'b0, err}, 32'h0);
    check("reset_rty", {31'b0, rty}, 32'h0);
    check("reset_sdt", sdt, 32'h0);
    rst_n = 1'b1;

    // classic table
    for (int i = 0; i < 15; i++) begin
      classic(vecs[i].we, vecs[i].adr, vecs[i].dat, vecs[i].sel, rd, lat, ga, ge, tail);
      check($sformatf("v%0d_latency", i), lat, 32'd1);
      check($sformatf("v%0d_ack_err", i), {30'b0, ga, ge}, {30'b0, ~vecs[i].exp_err, vecs[i].exp_err});
      check($sformatf("v%0d_drop", i), {31'b0, tail}, 32'h1);
      if (vecs[i].chk_dat) check($sformatf("v%0d_rdata", i), rd, vecs[i].exp_dat);
    end

    // linear write burst of 8 at 0x100, then read back
    for (int i = 0; i < 8; i++) wbuf[i] = 32'(i + 1);
    burst(32'h100, 3'b010, 2'b00, 8, 1'b1, acks, cycles, serr);
    check("lin_wr_acks", acks, 32'd8);
    check("lin_wr_cycles", cycles, 32'd9);
    check("lin_wr_idle", {30'b0, ack, err}, 32'h0);
    burst(32'h100, 3'b010, 2'b00, 8, 1'b0, acks, cycles, serr);
    check("lin_rd_cycles", cycles, 32'd9);
    for (int i = 0; i < 8; i++) check($sformatf("lin_rd_%0d", i), rbuf[i], 32'(i + 1));

    // wrap-4 read starting at 0x0C
    for (int i = 0; i < 4; i++) wbuf[i] = 32'hA0 + 32'(i);
    burst(32'h0, 3'b010, 2'b00, 4, 1'b1, acks, cycles, serr);
    burst(32'h0C, 3'b010, 2'b01, 4, 1'b0, acks, cycles, serr);
    check("wrap4_cycles", cycles, 32'd5);
    check("wrap4_0", rbuf[0], 32'hA3);
    check("wrap4_1", rbuf[1], 32'hA0);
    check("wrap4_2", rbuf[2], 32'hA1);
    check("wrap4_3", rbuf[3], 32'hA2);

    // wrap-8 read starting at 0x104: words 2..8 then 1
    burst(32'h104, 3'b010, 2'b10, 8, 1'b0, acks, cycles, serr);
    check("wrap8_cycles", cycles, 32'd9);
    for (int i = 0; i < 8; i++) check($sformatf("wrap8_%0d", i), rbuf[i], (i == 7) ? 32'd1 : 32'(i + 2));

    // constant burst at 0x20
    burst(32'h20, 3'b001, 2'b00, 4, 1'b0, acks, cycles, serr);
    check("const_acks", acks, 32'd4);
    for (int i = 0; i < 4; i++) check($sformatf("const_%0d", i), rbuf[i], 32'hC0FFEE00);

    // linear burst running off the end of memory
    burst(32'hFF8, 3'b010, 2'b00, 4, 1'b0, acks, cycles, serr);
    check("edge_acks", acks, 32'd2);
    check("edge_err", {31'b0, serr}, 32'h1);
    check("edge_cycles", cycles, 32'd4);
    check("edge_d0", rbuf[0], 32'h87654321);
    check("edge_d1", rbuf[1], 32'h12345678);
    check("edge_idle", {30'b0, ack, err}, 32'h0);

    // stall: drop stb mid-burst, then restart
    @(posedge clk); #1;
    adr = 32'h100; sel = 4'hF; we = 1'b0; cti = 3'b010; bte = 2'b00; cyc = 1'b1; stb = 1'b1;
    @(posedge clk); #1;
    check("stall_first", {ack, sdt[30:0]}, {1'b1, 31'd1});
    @(posedge clk); #1;
    adr = 32'h104;
    check("stall_beat1", {ack, sdt[30:0]}, {1'b1, 31'd2});
    @(posedge clk); #1;
    adr = 32'h108; stb = 1'b0;
    @(posedge clk); #1;
    check("stall_ack_low", {31'b0, ack}, 32'h0);
    stb = 1'b1; cti = 3'b111;
    @(posedge clk); #1;
    check("restart_ack", {ack, sdt[30:0]}, {1'b1, 31'd3});
    @(posedge clk); #1;
    check("restart_end", {31'b0, ack}, 32'h0);
    cyc = 1'b0; stb = 1'b0; cti = 3'b000;

    // reset asserted mid-burst
    @(posedge clk); #1;
    adr = 32'h100; cti = 3'b010; bte = 2'b00; cyc = 1'b1; stb = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    adr = 32'h104;
    check("prereset_ack", {31'b0, ack}, 32'h1);
    #3 rst_n = 1'b0;
    #1;
    check("midrst_ack", {31'b0, ack}, 32'h0);
    check("midrst_sdt", sdt, 32'h0);
    cyc = 1'b0; stb = 1'b0; cti = 3'b000;
    @(negedge clk);
    rst_n = 1'b1;

    // memory survives reset
    classic(1'b0, 32'h104, 32'h0, 4'hF, rd, lat, ga, ge, tail);
    check("post_rst_lat", lat, 32'd1);
    check("post_rst_data", rd, 32'd2);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
